// File: rtl/mpu_pkg.sv
// Purpose: shared widths, context record, fault FSM states and base context
//          for the MPU context sequencer and its LIFO.
// Ports:   none (package).
package mpu_pkg;

  localparam int unsigned Depth     = 8;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned PrioWidth = 8;
  localparam int unsigned AddrWidth = 16;
  localparam int unsigned DepthW    = $clog2(Depth + 1);
  localparam int unsigned IdxW      = $clog2(Depth);

  // One interrupt context as seen by the MPU
  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [PrioWidth-1:0] prio;
    logic [AddrWidth-1:0] ep;
  } ctx_t;

  typedef enum logic {
    FAULT_IDLE = 1'b0,
    FAULT_PEND = 1'b1
  } fault_state_e;

  localparam ctx_t CtxBase = '0;

endpackage

// File: rtl/mpu_ctx_lifo.sv
// Purpose: Depth-entry register stack of preempted contexts.
// Ports:   i_clk, i_reset (async, active-high)
//          i_push/i_push_data   : store a context at the top
//          i_pop                : discard the top context
//          i_replace/i_replace_data : overwrite the top context in place
//          o_top_c (comb), o_depth (reg), o_full_c, o_empty_c (comb)
module mpu_ctx_lifo
  import mpu_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_push,
  input  ctx_t              i_push_data,
  input  logic              i_pop,
  input  logic              i_replace,
  input  ctx_t              i_replace_data,
  output ctx_t              o_top_c,
  output logic [DepthW-1:0] o_depth,
  output logic              o_full_c,
  output logic              o_empty_c
);

  ctx_t              r_stack [Depth];
  logic [DepthW-1:0] r_depth;
  logic [IdxW-1:0]   w_wr_idx;
  logic [IdxW-1:0]   w_top_idx;

  // Index truncation is safe: writes are gated by full, top reads by empty
  assign w_wr_idx  = IdxW'(r_depth);
  assign w_top_idx = IdxW'(r_depth - DepthW'(1));

  assign o_top_c   = r_stack[w_top_idx];
  assign o_depth   = r_depth;
  assign o_full_c  = (r_depth == DepthW'(Depth));
  assign o_empty_c = (r_depth == '0);

  // Stack storage and occupancy; push has priority over pop, pop over replace
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        r_stack[i] <= CtxBase;
      end
      r_depth <= '0;
    end else if (i_push && !o_full_c) begin
      r_stack[w_wr_idx] <= i_push_data;
      r_depth           <= r_depth + DepthW'(1);
    end else if (i_pop && !o_empty_c) begin
      r_depth <= r_depth - DepthW'(1);
    end else if (i_replace && !o_empty_c) begin
      r_stack[w_top_idx] <= i_replace_data;
    end
  end

endmodule

// File: rtl/mpu_ctx_sequencer.sv
// Purpose: tracks the active interrupt context across nesting, drives it to
//          the MPU with a reload pulse, and forwards MPU faults to n-clic.
// Ports:   i_clk, i_reset (async, active-high)
//          i_irq_take/i_irq_id/i_irq_prio/i_sp, i_irq_ret : n-clic dispatch/return
//          o_cur_id/o_cur_prio/o_cur_ep, o_depth, o_ctx_changed : active context
//          i_mem_fault/i_fault_addr : MPU fault input
//          o_fault_valid/i_fault_ready/o_fault_id/o_fault_addr_q : fault record
//          o_err_ovf/o_err_unf/o_err_prio/o_fault_lost, i_clr_err : sticky errors
module mpu_ctx_sequencer
  import mpu_pkg::*;
(
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_irq_take,
  input  logic [IdWidth-1:0]   i_irq_id,
  input  logic [PrioWidth-1:0] i_irq_prio,
  input  logic [AddrWidth-1:0] i_sp,
  input  logic                 i_irq_ret,
  output logic [IdWidth-1:0]   o_cur_id,
  output logic [PrioWidth-1:0] o_cur_prio,
  output logic [AddrWidth-1:0] o_cur_ep,
  output logic [DepthW-1:0]    o_depth,
  output logic                 o_ctx_changed,
  input  logic                 i_mem_fault,
  input  logic [AddrWidth-1:0] i_fault_addr,
  output logic                 o_fault_valid,
  input  logic                 i_fault_ready,
  output logic [IdWidth-1:0]   o_fault_id,
  output logic [AddrWidth-1:0] o_fault_addr_q,
  output logic                 o_err_ovf,
  output logic                 o_err_unf,
  output logic                 o_err_prio,
  output logic                 o_fault_lost,
  input  logic                 i_clr_err
);

  ctx_t         r_cur;
  fault_state_e r_fstate;
  ctx_t         w_top;
  ctx_t         w_new;
  logic         w_full, w_empty;
  logic         w_tail_chain, w_gt_cur, w_gt_top;
  logic         w_push, w_pop, w_load;
  logic         w_set_ovf, w_set_unf, w_set_prio;

  assign w_new = '{id: i_irq_id, prio: i_irq_prio, ep: i_sp};

  mpu_ctx_lifo u_lifo (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_push         (w_push),
    .i_push_data    (r_cur),
    .i_pop          (w_pop),
    .i_replace      (1'b0),
    .i_replace_data (CtxBase),
    .o_top_c        (w_top),
    .o_depth        (o_depth),
    .o_full_c       (w_full),
    .o_empty_c      (w_empty)
  );

  // Take/return arbitration; a tail-chain checks priority against the context it returns to
  always_comb begin
    w_tail_chain = i_irq_take & i_irq_ret & ~w_empty;
    w_gt_cur     = (i_irq_prio > r_cur.prio);
    w_gt_top     = (i_irq_prio > w_top.prio);
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_load       = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_prio   = 1'b0;
    w_set_unf    = i_irq_ret & w_empty;
    if (w_tail_chain) begin
      if (w_gt_top) begin
        w_load = 1'b1;
      end else begin
        w_pop      = 1'b1;
        w_set_prio = 1'b1;
      end
    end else begin
      if (i_irq_ret && !w_empty) begin
        w_pop = 1'b1;
      end
      if (i_irq_take) begin
        w_set_ovf  = w_full;
        w_set_prio = ~w_gt_cur;
        w_push     = ~w_full & w_gt_cur;
        w_load     = ~w_full & w_gt_cur;
      end
    end
  end

  assign o_cur_id   = r_cur.id;
  assign o_cur_prio = r_cur.prio;
  assign o_cur_ep   = r_cur.ep;

  // Active context, reload pulse, sticky errors and fault handshake FSM
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cur          <= CtxBase;
      o_ctx_changed  <= 1'b0;
      r_fstate       <= FAULT_IDLE;
      o_fault_valid  <= 1'b0;
      o_fault_id     <= '0;
      o_fault_addr_q <= '0;
      o_err_ovf      <= 1'b0;
      o_err_unf      <= 1'b0;
      o_err_prio     <= 1'b0;
      o_fault_lost   <= 1'b0;
    end else begin
      if (w_load) begin
        r_cur <= w_new;
      end else if (w_pop) begin
        r_cur <= w_top;
      end
      o_ctx_changed <= w_load | w_pop;

      case (r_fstate)
        FAULT_IDLE: begin
          if (i_mem_fault) begin
            r_fstate       <= FAULT_PEND;
            o_fault_valid  <= 1'b1;
            o_fault_id     <= r_cur.id;
            o_fault_addr_q <= i_fault_addr;
          end
        end
        FAULT_PEND: begin
          if (i_fault_ready) begin
            r_fstate      <= FAULT_IDLE;
            o_fault_valid <= 1'b0;
          end
        end
        default: begin
          r_fstate      <= FAULT_IDLE;
          o_fault_valid <= 1'b0;
        end
      endcase

      // Clear takes precedence over any same-cycle set
      if (i_clr_err) begin
        o_err_ovf    <= 1'b0;
        o_err_unf    <= 1'b0;
        o_err_prio   <= 1'b0;
        o_fault_lost <= 1'b0;
      end else begin
        o_err_ovf    <= o_err_ovf | w_set_ovf;
        o_err_unf    <= o_err_unf | w_set_unf;
        o_err_prio   <= o_err_prio | w_set_prio;
        o_fault_lost <= o_fault_lost | (i_mem_fault & (r_fstate == FAULT_PEND));
      end
    end
  end

endmodule
